// File: rtl/ast_packet_arbiter.sv
// Packet-granular round-robin arbiter: N_SRC Avalon-ST sources share one sink.
// A grant is locked from arbitration until the granted source's eop beat is accepted.
module ast_packet_arbiter #(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned EMPTY_W   = ($clog2(DATA_W / 8) == 0) ? 1 : $clog2(DATA_W / 8),
    parameter int unsigned CHANNEL_W = 10,
    parameter int unsigned GRANT_W   = $clog2(N_SRC)
) (
    input  logic                         clk_i,
    input  logic                         arstn_i,
    input  logic [N_SRC*DATA_W-1:0]      ast_data_i,
    input  logic [N_SRC-1:0]             ast_startofpacket_i,
    input  logic [N_SRC-1:0]             ast_endofpacket_i,
    input  logic [N_SRC-1:0]             ast_valid_i,
    input  logic [N_SRC*EMPTY_W-1:0]     ast_empty_i,
    input  logic [N_SRC*CHANNEL_W-1:0]   ast_channel_i,
    output logic [N_SRC-1:0]             ast_ready_o,
    output logic [DATA_W-1:0]            ast_data_o,
    output logic                         ast_startofpacket_o,
    output logic                         ast_endofpacket_o,
    output logic                         ast_valid_o,
    output logic [EMPTY_W-1:0]           ast_empty_o,
    output logic [CHANNEL_W-1:0]         ast_channel_o,
    input  logic                         ast_ready_i,
    output logic [GRANT_W-1:0]           grant_o,
    output logic                         busy_o
);

    localparam logic [GRANT_W:0] NSrcExt = (GRANT_W + 1)'(N_SRC);

    typedef enum logic [0:0] {StIdle, StPkt} state_e;

    state_e             state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] ptr_q, ptr_d;

    logic               pick_found;
    logic [GRANT_W-1:0] pick_idx;
    logic [GRANT_W-1:0] grant_inc;

    logic [DATA_W-1:0]    sel_data;
    logic                 sel_sop;
    logic                 sel_eop;
    logic                 sel_valid;
    logic [EMPTY_W-1:0]   sel_empty;
    logic [CHANNEL_W-1:0] sel_channel;

    // Fields of the granted source; only valid is qualified by state below.
    always_comb begin
        sel_data    = ast_data_i[int'(grant_q) * DATA_W +: DATA_W];
        sel_empty   = ast_empty_i[int'(grant_q) * EMPTY_W +: EMPTY_W];
        sel_channel = ast_channel_i[int'(grant_q) * CHANNEL_W +: CHANNEL_W];
        sel_sop     = ast_startofpacket_i[grant_q];
        sel_eop     = ast_endofpacket_i[grant_q];
        sel_valid   = ast_valid_i[grant_q];
    end

    // First valid source scanning upward from the pointer, wrapping at N_SRC.
    always_comb begin
        logic [GRANT_W:0] idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = '0;
        for (int unsigned off = 0; off < N_SRC; off++) begin
            idx = {1'b0, ptr_q} + (GRANT_W + 1)'(off);
            if (idx >= NSrcExt) begin
                idx = idx - NSrcExt;
            end
            if (!pick_found && ast_valid_i[idx[GRANT_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = idx[GRANT_W-1:0];
            end
        end
    end

    always_comb begin
        logic [GRANT_W:0] inc;
        inc = {1'b0, grant_q} + 1'b1;
        if (inc == NSrcExt) begin
            inc = '0;
        end
        grant_inc = inc[GRANT_W-1:0];
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = StPkt;
                end
            end
            StPkt: begin
                if (sel_valid && ast_ready_i && sel_eop) begin
                    state_d = StIdle;
                    ptr_d   = grant_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o              = (state_q == StPkt);
        grant_o             = grant_q;
        ast_valid_o         = (state_q == StPkt) && sel_valid;
        ast_data_o          = sel_data;
        ast_startofpacket_o = sel_sop;
        ast_endofpacket_o   = sel_eop;
        ast_empty_o         = sel_empty;
        ast_channel_o       = sel_channel;
        ast_ready_o         = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            ast_ready_o[i] = (state_q == StPkt) && (grant_q == GRANT_W'(i)) && ast_ready_i;
        end
    end

endmodule

// File: tb/tb_ast_packet_arbiter.sv
// Directed bench for ast_packet_arbiter with N_SRC=4, DATA_W=64.
module tb_ast_packet_arbiter;

    logic         clk = 1'b0;
    logic         arstn;
    logic [255:0] data_in;
    logic [3:0]   sop_in;
    logic [3:0]   eop_in;
    logic [3:0]   valid_in;
    logic [11:0]  empty_in;
    logic [39:0]  channel_in;
    logic [3:0]   ready_out;
    logic [63:0]  data_out;
    logic         sop_out;
    logic         eop_out;
    logic         valid_out;
    logic [2:0]   empty_out;
    logic [9:0]   channel_out;
    logic         ready_in;
    logic [1:0]   grant;
    logic         busy;

    int checks = 0;
    int errors = 0;

    ast_packet_arbiter #(
        .N_SRC     (4),
        .DATA_W    (64),
        .EMPTY_W   (3),
        .CHANNEL_W (10),
        .GRANT_W   (2)
    ) dut (
        .clk_i               (clk),
        .arstn_i             (arstn),
        .ast_data_i          (data_in),
        .ast_startofpacket_i (sop_in),
        .ast_endofpacket_i   (eop_in),
        .ast_valid_i         (valid_in),
        .ast_empty_i         (empty_in),
        .ast_channel_i       (channel_in),
        .ast_ready_o         (ready_out),
        .ast_data_o          (data_out),
        .ast_startofpacket_o (sop_out),
        .ast_endofpacket_o   (eop_out),
        .ast_valid_o         (valid_out),
        .ast_empty_o         (empty_out),
        .ast_channel_o       (channel_out),
        .ast_ready_i         (ready_in),
        .grant_o             (grant),
        .busy_o              (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic v, input logic sop, input logic eop,
                           input logic [63:0] d, input logic [2:0] e, input logic [9:0] ch);
        valid_in[s]           = v;
        sop_in[s]             = sop;
        eop_in[s]             = eop;
        data_in[s*64 +: 64]   = d;
        empty_in[s*3 +: 3]    = e;
        channel_in[s*10 +: 10] = ch;
    endtask

    task automatic clr_src(input int s);
        set_src(s, 1'b0, 1'b0, 1'b0, 64'h0, 3'd0, 10'd0);
    endtask

    logic [1:0] rr_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        arstn      = 1'b0;
        data_in    = '0;
        sop_in     = '0;
        eop_in     = '0;
        valid_in   = '0;
        empty_in   = '0;
        channel_in = '0;
        ready_in   = 1'b1;

        // Reset state
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_ready", ready_out, 0);
        step();
        step();
        arstn = 1'b1;

        // Source 2, 3-beat packet
        set_src(2, 1, 1, 0, 64'h11, 0, 0);
        #1;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_valid", valid_out, 0);
        chk("t1_idle_ready", ready_out, 0);
        step();
        chk("t1_grant", grant, 2);
        chk("t1_busy", busy, 1);
        chk("t1_valid0", valid_out, 1);
        chk("t1_data0", data_out, 64'h11);
        chk("t1_sop0", sop_out, 1);
        chk("t1_ready0", ready_out, 4'b0100);
        step();
        set_src(2, 1, 0, 0, 64'h22, 0, 0);
        #1;
        chk("t1_data1", data_out, 64'h22);
        chk("t1_ready1", ready_out, 4'b0100);
        step();
        set_src(2, 1, 0, 1, 64'h33, 0, 0);
        #1;
        chk("t1_data2", data_out, 64'h33);
        chk("t1_eop2", eop_out, 1);
        step();
        clr_src(2);
        #1;
        chk("t1_end_busy", busy, 0);
        chk("t1_end_valid", valid_out, 0);
        chk("t1_end_grant", grant, 2);
        chk("t1_end_ready", ready_out, 0);

        // Pointer 3: single-beat from source 3, then source 0
        set_src(3, 1, 1, 1, 64'hAA, 3'd5, 10'h2A);
        set_src(0, 1, 1, 1, 64'hB0, 3'd0, 10'h0);
        #1;
        step();
        chk("t4_grant3", grant, 3);
        chk("t4_valid", valid_out, 1);
        chk("t4_empty", empty_out, 5);
        chk("t4_channel", channel_out, 10'h2A);
        chk("t4_eop", eop_out, 1);
        chk("t4_ready", ready_out, 4'b1000);
        step();
        clr_src(3);
        #1;
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_valid", valid_out, 0);
        step();
        chk("t4_grant0", grant, 0);
        chk("t4_data0", data_out, 64'hB0);
        chk("t4_ready0", ready_out, 4'b0001);
        step();
        clr_src(0);
        #1;
        chk("t4_end_busy", busy, 0);

        // Pointer 1: source 1 with ready toggling
        set_src(1, 1, 1, 0, 64'hC1, 0, 0);
        #1;
        step();
        chk("t3_grant", grant, 1);
        chk("t3_ready_a", ready_out, 4'b0010);
        chk("t3_data_a", data_out, 64'hC1);
        step();
        set_src(1, 1, 0, 0, 64'hC2, 0, 0);
        ready_in = 1'b0;
        #1;
        chk("t3_ready_b", ready_out, 4'b0000);
        chk("t3_valid_b", valid_out, 1);
        chk("t3_data_b", data_out, 64'hC2);
        step();
        ready_in = 1'b1;
        #1;
        chk("t3_ready_c", ready_out, 4'b0010);
        chk("t3_data_c", data_out, 64'hC2);
        step();
        set_src(1, 1, 0, 1, 64'hC3, 0, 0);
        ready_in = 1'b0;
        #1;
        chk("t3_ready_d", ready_out, 4'b0000);
        chk("t3_data_d", data_out, 64'hC3);
        chk("t3_busy_d", busy, 1);
        step();
        ready_in = 1'b1;
        #1;
        chk("t3_ready_e", ready_out, 4'b0010);
        chk("t3_data_e", data_out, 64'hC3);
        step();
        clr_src(1);
        #1;
        chk("t3_end_busy", busy, 0);

        // Pointer 2: source 2 with a 4-cycle valid gap, source 1 waiting
        set_src(2, 1, 1, 0, 64'hD1, 0, 0);
        set_src(1, 1, 1, 1, 64'hE1, 0, 0);
        #1;
        step();
        chk("t5_grant", grant, 2);
        chk("t5_data0", data_out, 64'hD1);
        chk("t5_ready0", ready_out, 4'b0100);
        step();
        set_src(2, 1, 0, 0, 64'hD2, 0, 0);
        #1;
        chk("t5_data1", data_out, 64'hD2);
        step();
        set_src(2, 0, 0, 0, 64'hD2, 0, 0);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_gap_valid", valid_out, 0);
            chk("t5_gap_busy", busy, 1);
            chk("t5_gap_grant", grant, 2);
            chk("t5_gap_ready1", ready_out[1], 0);
            step();
        end
        set_src(2, 1, 0, 1, 64'hD3, 0, 0);
        #1;
        chk("t5_valid2", valid_out, 1);
        chk("t5_data2", data_out, 64'hD3);
        step();
        clr_src(2);
        #1;
        chk("t5_idle_busy", busy, 0);
        step();
        chk("t5_grant1", grant, 1);
        chk("t5_data_e1", data_out, 64'hE1);
        step();
        clr_src(1);
        #1;
        chk("t5_end_busy", busy, 0);

        // Pointer 2: lone source 3 moves pointer to 0
        set_src(3, 1, 1, 1, 64'hF3, 0, 0);
        #1;
        step();
        chk("t6_grant", grant, 3);
        chk("t6_data", data_out, 64'hF3);
        step();
        clr_src(3);

        // Pointer 0: all sources request 2-beat packets
        for (int s = 0; s < 4; s++) begin
            set_src(s, 1, 1, 0, 64'(s) << 8, 0, 0);
        end
        for (int p = 0; p < 5; p++) begin
            #1;
            chk("rr_idle_busy", busy, 0);
            chk("rr_idle_valid", valid_out, 0);
            step();
            chk("rr_grant", grant, rr_order[p]);
            chk("rr_data0", data_out, 64'(rr_order[p]) << 8);
            chk("rr_sop", sop_out, 1);
            step();
            set_src(int'(rr_order[p]), 1, 0, 1, (64'(rr_order[p]) << 8) | 64'h1, 0, 0);
            #1;
            chk("rr_data1", data_out, (64'(rr_order[p]) << 8) | 64'h1);
            chk("rr_eop", eop_out, 1);
            chk("rr_ready", ready_out, 4'b0001 << rr_order[p]);
            step();
            set_src(int'(rr_order[p]), 1, 1, 0, 64'(rr_order[p]) << 8, 0, 0);
        end
        for (int s = 0; s < 4; s++) begin
            clr_src(s);
        end

        // Asynchronous reset mid-packet
        set_src(2, 1, 1, 0, 64'h55, 0, 0);
        #1;
        step();
        chk("rs_grant", grant, 2);
        chk("rs_busy", busy, 1);
        chk("rs_valid", valid_out, 1);
        #2;
        arstn = 1'b0;
        #1;
        chk("rs_async_valid", valid_out, 0);
        chk("rs_async_ready", ready_out, 0);
        chk("rs_async_busy", busy, 0);
        chk("rs_async_grant", grant, 0);
        clr_src(2);
        step();
        step();
        arstn = 1'b1;
        set_src(1, 1, 1, 1, 64'h77, 0, 0);
        #1;
        chk("rs_idle_busy", busy, 0);
        step();
        chk("rs_grant1", grant, 1);
        chk("rs_busy1", busy, 1);
        chk("rs_data1", data_out, 64'h77);
        step();
        clr_src(1);
        #1;
        chk("rs_end_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
